udp_rx: RTL
===========

# udp_rx

Receive-side UDP parser in the Ethernet stack, directly downstream of the IP receive stage. It starts on that stage's one-cycle UDP request pulse and consumes the IP payload byte stream. It extracts the 8-byte UDP header, validates length and destination port, and forwards payload bytes with a valid strobe. It verifies the UDP checksum over the pseudo-header, header and payload, and reports it in a one-cycle end pulse.

## Interface
Parameters:
- CHECK_ZERO_CSUM, 0, when 1 a received checksum of 16'h0000 is checked like any other value; when 0 a zero checksum means "not computed" and is never an error.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- udp_rx_req  in  1  one-cycle pulse; first UDP header byte appears on udp_rx_data in the following cycle.
- udp_rx_data  in  8  IP payload byte stream, one byte per cycle, no gaps.
- ip_upper_len  in  16  IP payload length in bytes (IP total length minus IP header length).
- ip_src_addr  in  32  source IP, for the pseudo-header.
- ip_dst_addr  in  32  destination IP, for the pseudo-header.
- rx_abort  in  1  upstream IP checksum error or address error.
- local_udp_port  in  16  port this node accepts.
- udp_src_port  out  16  received source port.
- udp_dst_port  out  16  received destination port.
- udp_data_len  out  16  UDP length field minus 8.
- udp_data  out  8  payload byte.
- udp_data_valid  out  1  qualifies udp_data.
- udp_rx_end  out  1  one-cycle end-of-datagram pulse.
- udp_checksum_error  out  1  valid only with udp_rx_end.
- udp_port_error  out  1  valid only with udp_rx_end.
- udp_len_error  out  1  valid only with udp_rx_end.
- udp_rx_drop  out  1  one-cycle pulse when a datagram is discarded by rx_abort.

## Operation
- State machine:
  - IDLE -> HEADER on udp_rx_req.
  - HEADER -> DATA at header byte 7 when the length field is greater than 8.
  - HEADER -> CHECK at header byte 7 when the length field equals 8.
  - DATA -> CHECK on the last payload byte (byte index = length field - 1).
  - CHECK -> END.
  - END -> IDLE.
- Header bytes are taken big-endian:
  - bytes 0-1: source port.
  - bytes 2-3: destination port.
  - bytes 4-5: length.
  - bytes 6-7: checksum.
- Length validation at byte 5: if the length field is below 8 or above ip_upper_len, go straight to END with udp_len_error=1. Payload is not forwarded and the checksum is not evaluated (udp_checksum_error=0).
- Port check: if udp_dst_port differs from local_udp_port, udp_data_valid stays 0 for the whole datagram, the checksum is still computed, and END reports udp_port_error=1.
- Checksum: the accumulator is a 32-bit one's-complement sum of 16-bit words, preloaded with:
  - ip_src_addr[31:16] + ip_src_addr[15:0]
  - ip_dst_addr[31:16] + ip_dst_addr[15:0]
  - 16'h0011
  - the UDP length field, added once it is known.
- The header and payload are summed as big-endian pairs. An odd final byte is padded with 8'h00 in the low byte.
- CHECK folds the sum twice (sum[15:0]+sum[31:16], then add the carry). The result must equal 16'hFFFF; otherwise udp_checksum_error=1.
- A received checksum of 0 with CHECK_ZERO_CSUM=0 forces udp_checksum_error=0.
- Trailing Ethernet padding beyond the UDP length field is ignored.
- rx_abort in any non-IDLE state: return to IDLE next cycle, pulse udp_rx_drop, suppress udp_rx_end, and drive udp_data_valid=0 from that cycle on.
- rx_abort in IDLE is ignored.
- udp_rx_req while not IDLE is ignored.

## Timing
- Reset: all outputs are 0, the state is IDLE, and the accumulator is cleared.
- rst mid-datagram: the same as reset; no end or drop pulse is produced.
- Port and length outputs are registered; they update on the cycle after their last byte and hold until the next udp_rx_req.
- Payload byte on udp_rx_data in cycle t -> udp_data/udp_data_valid in cycle t+1.
- Last payload byte (or header byte 7 when length = 8) in cycle t -> udp_rx_end in cycle t+3, for exactly one cycle, with all error flags.
- Length error detected at byte 5 in cycle t -> udp_rx_end in cycle t+2.
- Back-to-back: a new udp_rx_req is accepted in the IDLE cycle immediately after END.

## Structure
- Shared package holds:
  - state encodings (one-hot, 5 bits: IDLE, HEADER, DATA, CHECK, END).
  - UDP_HDR_LEN = 16'd8.
  - IP_PROTO_UDP = 8'h11.
- Sub-module udp_csum_acc: clear/preload/add-word/fold one's-complement accumulator. It is reusable by the ICMP receive stage and the UDP transmit stage.

## Test plan
- Valid datagram:
  - stimulus: src 192.168.1.2, dst 192.168.1.10, ports 0x1F90->0x1234, local port 0x1234, length 12, payload DE AD BE EF, correct checksum.
  - response: 4 valid bytes, end at last byte +3, all errors 0, udp_data_len=4.
- Same datagram, checksum byte 7 flipped -> payload forwarded, udp_checksum_error=1.
- Checksum 0x0000 with CHECK_ZERO_CSUM=0 -> udp_checksum_error=0.
- Odd payload (length 13, payload adds byte 0x5A) -> pad handled, checksum passes.
- Destination port 0x4321 vs local 0x1234 -> no udp_data_valid, udp_port_error=1.
- Error and abort cases:
  - length field 6 -> udp_len_error=1, no valid bytes.
  - rx_abort at payload byte 2 -> udp_rx_drop pulse, no udp_rx_end, next udp_rx_req parses normally.

Source files
------------

// File: rtl/udp_rx_pkg.sv
// rtl/udp_rx_pkg.sv - shared types and constants for the UDP receive path
package udp_rx_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_HEADER = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_CHECK  = 5'b01000,
    ST_END    = 5'b10000
  } udp_rx_state_t;

  localparam logic [15:0] UDP_HDR_LEN  = 16'd8;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;

  // Pseudo-header contribution known at request time (length is added later)
  function automatic logic [31:0] pseudo_hdr_sum(input logic [31:0] src, input logic [31:0] dst);
    return {16'h0, src[31:16]} + {16'h0, src[15:0]} +
           {16'h0, dst[31:16]} + {16'h0, dst[15:0]} +
           {24'h0, IP_PROTO_UDP};
  endfunction

endpackage

// File: rtl/udp_rx_if.sv
// rtl/udp_rx_if.sv - IP-payload input stream and parsed UDP output bundle
interface udp_rx_if;
  logic        udp_rx_req;
  logic [7:0]  udp_rx_data;
  logic [15:0] ip_upper_len;
  logic [31:0] ip_src_addr;
  logic [31:0] ip_dst_addr;
  logic        rx_abort;

  logic [15:0] udp_src_port;
  logic [15:0] udp_dst_port;
  logic [15:0] udp_data_len;
  logic [7:0]  udp_data;
  logic        udp_data_valid;
  logic        udp_rx_end;
  logic        udp_checksum_error;
  logic        udp_port_error;
  logic        udp_len_error;
  logic        udp_rx_drop;

  modport master (
    output udp_rx_req, udp_rx_data, ip_upper_len, ip_src_addr, ip_dst_addr, rx_abort,
    input  udp_src_port, udp_dst_port, udp_data_len, udp_data, udp_data_valid,
           udp_rx_end, udp_checksum_error, udp_port_error, udp_len_error, udp_rx_drop
  );

  modport slave (
    input  udp_rx_req, udp_rx_data, ip_upper_len, ip_src_addr, ip_dst_addr, rx_abort,
    output udp_src_port, udp_dst_port, udp_data_len, udp_data, udp_data_valid,
           udp_rx_end, udp_checksum_error, udp_port_error, udp_len_error, udp_rx_drop
  );
endinterface

// File: rtl/udp_rx_csum_acc.sv
// rtl/udp_rx_csum_acc.sv - one's-complement checksum accumulator (clear/preload/add/fold)
module udp_csum_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        preload_en,
  input  logic [31:0] preload_val,
  input  logic        add_en,
  input  logic [15:0] add_word,
  output logic [15:0] folded
);

  logic [31:0] acc;
  logic [16:0] fold1;

  // Clear, preload and add may coincide; carries are kept in the upper half until folding
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 32'h0;
    end else begin
      acc <= (clear ? 32'h0 : acc)
           + (preload_en ? preload_val : 32'h0)
           + (add_en ? {16'h0, add_word} : 32'h0);
    end
  end

  always_comb begin
    fold1  = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    folded = fold1[15:0] + {15'h0, fold1[16]};
  end

endmodule

// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - UDP header parser, payload forwarder and checksum verifier
module udp_rx
  import udp_rx_pkg::*;
#(
  parameter bit CHECK_ZERO_CSUM = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] local_udp_port,
  udp_rx_if.slave     rx
);

  udp_rx_state_t state;
  logic [15:0]   pos;
  logic [15:0]   len_q;
  logic [15:0]   csum_q;
  logic [7:0]    hi_byte;
  logic          port_ok;
  logic          len_err_q;
  logic          csum_err_q;

  logic [15:0]   pair_word;
  logic [15:0]   len_field;
  logic          len_bad;
  logic          last_byte;
  logic          active;

  logic          acc_clear;
  logic          acc_pre_en;
  logic [31:0]   acc_pre_val;
  logic          acc_add_en;
  logic [15:0]   acc_word;
  logic [15:0]   acc_folded;

  always_comb begin
    pair_word = {hi_byte, rx.udp_rx_data};
    len_field = pair_word;
    len_bad   = (len_field < UDP_HDR_LEN) || (len_field > rx.ip_upper_len);
    last_byte = (state == ST_DATA) && (pos == len_q - 16'd1);
    active    = (state == ST_HEADER) || (state == ST_DATA);
  end

  // Accumulator feed: pseudo-header on request, length at byte 5, then 16-bit pairs
  always_comb begin
    acc_clear   = 1'b0;
    acc_pre_en  = 1'b0;
    acc_pre_val = 32'h0;
    acc_add_en  = 1'b0;
    acc_word    = pair_word;
    if (state == ST_IDLE && rx.udp_rx_req) begin
      acc_clear   = 1'b1;
      acc_pre_en  = 1'b1;
      acc_pre_val = pseudo_hdr_sum(rx.ip_src_addr, rx.ip_dst_addr);
    end
    if (active && !rx.rx_abort) begin
      if (pos[0]) begin
        acc_add_en = 1'b1;
      end else if (last_byte) begin
        acc_add_en = 1'b1;
        acc_word   = {rx.udp_rx_data, 8'h00};
      end
      if (state == ST_HEADER && pos == 16'd5) begin
        acc_pre_en  = 1'b1;
        acc_pre_val = {16'h0, len_field};
      end
    end
  end

  udp_csum_acc u_csum (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear),
    .preload_en  (acc_pre_en),
    .preload_val (acc_pre_val),
    .add_en      (acc_add_en),
    .add_word    (acc_word),
    .folded      (acc_folded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_IDLE;
      pos                   <= 16'h0;
      len_q                 <= 16'h0;
      csum_q                <= 16'h0;
      hi_byte               <= 8'h0;
      port_ok               <= 1'b0;
      len_err_q             <= 1'b0;
      csum_err_q            <= 1'b0;
      rx.udp_src_port       <= 16'h0;
      rx.udp_dst_port       <= 16'h0;
      rx.udp_data_len       <= 16'h0;
      rx.udp_data           <= 8'h0;
      rx.udp_data_valid     <= 1'b0;
      rx.udp_rx_end         <= 1'b0;
      rx.udp_checksum_error <= 1'b0;
      rx.udp_port_error     <= 1'b0;
      rx.udp_len_error      <= 1'b0;
      rx.udp_rx_drop        <= 1'b0;
    end else begin
      rx.udp_data_valid     <= 1'b0;
      rx.udp_rx_end         <= 1'b0;
      rx.udp_checksum_error <= 1'b0;
      rx.udp_port_error     <= 1'b0;
      rx.udp_len_error      <= 1'b0;
      rx.udp_rx_drop        <= 1'b0;

      if (state != ST_IDLE && rx.rx_abort) begin
        state          <= ST_IDLE;
        rx.udp_rx_drop <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx.udp_rx_req) begin
              state      <= ST_HEADER;
              pos        <= 16'h0;
              port_ok    <= 1'b0;
              len_err_q  <= 1'b0;
              csum_err_q <= 1'b0;
            end
          end
          ST_HEADER: begin
            pos <= pos + 16'd1;
            if (!pos[0]) hi_byte <= rx.udp_rx_data;
            case (pos[2:0])
              3'd1: rx.udp_src_port <= pair_word;
              3'd3: begin
                rx.udp_dst_port <= pair_word;
                port_ok         <= (pair_word == local_udp_port);
              end
              3'd5: begin
                len_q <= len_field;
                if (len_bad) begin
                  len_err_q       <= 1'b1;
                  rx.udp_data_len <= 16'h0;
                  state           <= ST_END;
                end else begin
                  rx.udp_data_len <= len_field - UDP_HDR_LEN;
                end
              end
              3'd7: begin
                csum_q <= pair_word;
                state  <= (len_q == UDP_HDR_LEN) ? ST_CHECK : ST_DATA;
              end
              default: ;
            endcase
          end
          ST_DATA: begin
            pos               <= pos + 16'd1;
            rx.udp_data       <= rx.udp_rx_data;
            rx.udp_data_valid <= port_ok;
            if (!pos[0]) hi_byte <= rx.udp_rx_data;
            if (last_byte) state <= ST_CHECK;
          end
          ST_CHECK: begin
            // A zero checksum means "sender did not compute one" unless told otherwise
            csum_err_q <= (acc_folded != 16'hFFFF) && (CHECK_ZERO_CSUM || csum_q != 16'h0);
            state      <= ST_END;
          end
          ST_END: begin
            rx.udp_rx_end         <= 1'b1;
            rx.udp_checksum_error <= csum_err_q;
            rx.udp_port_error     <= ~port_ok;
            rx.udp_len_error      <= len_err_q;
            state                 <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
